// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo: processor <-> gold_ring network interface.
//   One FIFO per direction (ring->proc IN_DEPTH, proc->ring OUT_DEPTH).
//   Data vectors are [0:DATA_W-1]: index 0 is the VC bit, index DATA_W-1 the LSB.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   addr, d_in, d_out     processor register interface
//                         00 in-data, 01 in-status, 10 out-data, 11 out-status
//   nicEn, nicWrEn        access enable / write select
//   net_si/net_ri/net_di  ring -> NIC handshake and packet
//   net_so/net_ro/net_do  NIC -> ring handshake and packet
//   net_polarity          ring even/odd cycle; a head is sent only when its VC bit differs

// Simple circular buffer. Callers guarantee push only when not full and
// pop only when not empty.
module cardinal_nic_fifo_q #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [0:W-1]                 wdata,
    output logic [0:W-1]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [0:W-1]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

module cardinal_nic_fifo #(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);
    localparam int ICW = $clog2(IN_DEPTH+1);
    localparam int OCW = $clog2(OUT_DEPTH+1);

    logic [0:DATA_W-1] in_head, out_head;
    logic [ICW-1:0]    in_count;
    logic [OCW-1:0]    out_count;
    logic              in_empty, in_full, out_empty, out_full;
    logic              in_push, in_pop, out_push, out_pop;
    logic              rd, wr, out_wr, eligible, ovf;
    logic [7:0]        in_cnt8, out_cnt8;

    assign rd = nicEn && !nicWrEn && !reset;
    assign wr = nicEn &&  nicWrEn && !reset;

    // Ring -> processor
    assign net_ri  = !in_full && !reset;
    assign in_push = net_si && net_ri;
    assign in_pop  = rd && (addr == 2'b00) && !in_empty;

    // Processor -> ring; the full check uses the pre-edge count, so a write
    // while full is dropped even if a send frees a slot in the same cycle.
    assign out_wr   = wr && (addr == 2'b10);
    assign out_push = out_wr && !out_full;
    assign eligible = !out_empty && (out_head[0] != net_polarity);
    assign net_so   = eligible && net_ro && !reset;
    assign out_pop  = net_so;
    assign net_do   = (out_empty || reset) ? '0 : out_head;

    cardinal_nic_fifo_q #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_q (
        .clk(clk), .reset(reset), .push(in_push), .pop(in_pop), .wdata(net_di),
        .head(in_head), .count(in_count), .empty(in_empty), .full(in_full)
    );

    cardinal_nic_fifo_q #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_q (
        .clk(clk), .reset(reset), .push(out_push), .pop(out_pop), .wdata(d_in),
        .head(out_head), .count(out_count), .empty(out_empty), .full(out_full)
    );

    // Sticky overflow; set (addr 10 write) and clear (addr 11 read) never coincide.
    always_ff @(posedge clk) begin
        if (reset)                            ovf <= 1'b0;
        else if (out_wr && out_full)          ovf <= 1'b1;
        else if (rd && (addr == 2'b11))       ovf <= 1'b0;
    end

    assign in_cnt8  = 8'(in_count);
    assign out_cnt8 = 8'(out_count);

    // Status counts sit at [DATA_W-9:DATA_W-2], MSB leftmost.
    always_comb begin
        d_out = '0;
        if (rd) begin
            case (addr)
                2'b00: if (!in_empty) d_out = in_head;
                2'b01: begin
                    d_out[DATA_W-1]      = !in_empty;
                    d_out[DATA_W-9 +: 8] = in_cnt8;
                end
                2'b11: begin
                    d_out[DATA_W-1]      = out_full;
                    d_out[DATA_W-9 +: 8] = out_cnt8;
                    d_out[0]             = ovf;
                end
                default: ;
            endcase
        end
    end
endmodule
